// File: rtl/img2col_streamer_pkg.sv
// Shared constants, FSM encoding and width helper for the img2col transmit stream.
package img2col_streamer_pkg;

  // Tile edge shared with the serial-to-parallel collector; one tile = S2P_SIZE^2 beats.
  localparam int S2P_SIZE_DEF = 3;
  // Collector data width; carried here so both sides of the stream agree.
  localparam int DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/img2col_win_cnt.sv
// Nested wrap counters (f, oy, ox, c, ty, tx) for the img2col walk, plus running
// address bases. Tensor and weight addresses are accumulated modulo their SRAM
// width with adders only; out-of-range (padded) values are discarded by the top.
module img2col_win_cnt
  import img2col_streamer_pkg::*;
#(
  parameter int S2P_SIZE = 3,
  parameter int KSIZE    = 3,
  parameter int IMG_H    = 4,
  parameter int IMG_W    = 4,
  parameter int CH       = 1,
  parameter int NUM_FILT = 1,
  parameter int PAD      = 1,
  parameter int STRIDE   = 1,
  parameter int OH       = 4,
  parameter int OW       = 4,
  parameter int T_AW     = 4,
  parameter int W_AW     = 4,
  parameter int IW       = 6,
  parameter int CW       = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 adv_i,
  output logic [CW-1:0]        tx_o,
  output logic [CW-1:0]        ty_o,
  output logic signed [IW-1:0] iy_o,
  output logic signed [IW-1:0] ix_o,
  output logic [T_AW-1:0]      t_addr_o,
  output logic [W_AW-1:0]      w_addr_o,
  output logic                 last_o
);

  localparam int CCW = clog2_min1(CH);
  localparam int OXW = clog2_min1(OW);
  localparam int OYW = clog2_min1(OH);
  localparam int FW  = clog2_min1(NUM_FILT);

  localparam logic [CW-1:0]  T_MAX  = CW'(S2P_SIZE - 1);
  localparam logic [CCW-1:0] C_MAX  = CCW'(CH - 1);
  localparam logic [OXW-1:0] OX_MAX = OXW'(OW - 1);
  localparam logic [OYW-1:0] OY_MAX = OYW'(OH - 1);
  localparam logic [FW-1:0]  F_MAX  = FW'(NUM_FILT - 1);

  localparam logic signed [IW-1:0] PAD_NEG = IW'(-PAD);
  localparam logic signed [IW-1:0] STEP_I  = IW'(STRIDE);

  // Tensor-address terms, two's complement modulo 2^T_AW.
  localparam logic [T_AW-1:0] ROW_INIT = T_AW'(-PAD * IMG_W);
  localparam logic [T_AW-1:0] ROW_STEP = T_AW'(STRIDE * IMG_W);
  localparam logic [T_AW-1:0] W_STEP   = T_AW'(IMG_W);
  localparam logic [T_AW-1:0] HW_STEP  = T_AW'(IMG_H * IMG_W);

  localparam logic [W_AW-1:0] K_STEP   = W_AW'(KSIZE);
  localparam logic [W_AW-1:0] KK_STEP  = W_AW'(KSIZE * KSIZE);
  localparam logic [W_AW-1:0] FK_STEP  = W_AW'(CH * KSIZE * KSIZE);

  logic [CW-1:0]  tx_q, tx_d, ty_q, ty_d;
  logic [CCW-1:0] c_q, c_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [FW-1:0]  f_q, f_d;
  logic signed [IW-1:0] iy_base_q, iy_base_d, ix_base_q, ix_base_d;
  logic [T_AW-1:0] row_q, row_d, tyw_q, tyw_d, c_off_q, c_off_d;
  logic [W_AW-1:0] fw_q, fw_d, cw_q, cw_d, tyk_q, tyk_d;

  logic wrap_tx, wrap_ty, wrap_c, wrap_ox, wrap_oy, wrap_f;

  assign wrap_tx = (tx_q == T_MAX);
  assign wrap_ty = wrap_tx & (ty_q == T_MAX);
  assign wrap_c  = wrap_ty & (c_q == C_MAX);
  assign wrap_ox = wrap_c  & (ox_q == OX_MAX);
  assign wrap_oy = wrap_ox & (oy_q == OY_MAX);
  assign wrap_f  = wrap_oy & (f_q == F_MAX);

  // Carry cascade: each level steps when every inner level wraps on this beat.
  always_comb begin
    tx_d = tx_q; ty_d = ty_q; c_d = c_q; ox_d = ox_q; oy_d = oy_q; f_d = f_q;
    iy_base_d = iy_base_q; ix_base_d = ix_base_q;
    row_d = row_q; tyw_d = tyw_q; c_off_d = c_off_q;
    fw_d = fw_q; cw_d = cw_q; tyk_d = tyk_q;
    if (adv_i) begin
      tx_d = wrap_tx ? '0 : tx_q + 1'b1;
      if (wrap_tx) begin
        ty_d  = wrap_ty ? '0 : ty_q + 1'b1;
        tyw_d = wrap_ty ? '0 : tyw_q + W_STEP;
        tyk_d = wrap_ty ? '0 : tyk_q + K_STEP;
      end
      if (wrap_ty) begin
        c_d     = wrap_c ? '0 : c_q + 1'b1;
        c_off_d = wrap_c ? '0 : c_off_q + HW_STEP;
        cw_d    = wrap_c ? '0 : cw_q + KK_STEP;
      end
      if (wrap_c) begin
        ox_d      = wrap_ox ? '0 : ox_q + 1'b1;
        ix_base_d = wrap_ox ? PAD_NEG : ix_base_q + STEP_I;
      end
      if (wrap_ox) begin
        oy_d      = wrap_oy ? '0 : oy_q + 1'b1;
        iy_base_d = wrap_oy ? PAD_NEG : iy_base_q + STEP_I;
        row_d     = wrap_oy ? ROW_INIT : row_q + ROW_STEP;
      end
      if (wrap_oy) begin
        f_d  = wrap_f ? '0 : f_q + 1'b1;
        fw_d = wrap_f ? '0 : fw_q + FK_STEP;
      end
    end
  end

  // Counter and base registers; reset leaves the walk at the first beat of a job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_q <= '0; ty_q <= '0; c_q <= '0; ox_q <= '0; oy_q <= '0; f_q <= '0;
      iy_base_q <= PAD_NEG; ix_base_q <= PAD_NEG;
      row_q <= ROW_INIT; tyw_q <= '0; c_off_q <= '0;
      fw_q <= '0; cw_q <= '0; tyk_q <= '0;
    end else begin
      tx_q <= tx_d; ty_q <= ty_d; c_q <= c_d; ox_q <= ox_d; oy_q <= oy_d; f_q <= f_d;
      iy_base_q <= iy_base_d; ix_base_q <= ix_base_d;
      row_q <= row_d; tyw_q <= tyw_d; c_off_q <= c_off_d;
      fw_q <= fw_d; cw_q <= cw_d; tyk_q <= tyk_d;
    end
  end

  assign tx_o     = tx_q;
  assign ty_o     = ty_q;
  assign iy_o     = iy_base_q + IW'(ty_q);
  assign ix_o     = ix_base_q + IW'(tx_q);
  // c*H*W + (oy*S-PAD)*W + ty*W + (ox*S-PAD+tx) == c*H*W + iy*W + ix
  assign t_addr_o = c_off_q + row_q + tyw_q + T_AW'(ix_o);
  assign w_addr_o = fw_q + cw_q + tyk_q + W_AW'(tx_q);
  assign last_o   = wrap_f;

endmodule

// File: rtl/img2col_streamer.sv
// img2col transmit streamer: walks (f, oy, ox, c, ty, tx) and emits one beat per
// clock with tensor/weight SRAM addresses and zero-padding flags.
// Optional build macro IMG2COL_PAD_RDSKIP_EN: suppress SRAM read enables on padded beats.
module img2col_streamer
  import img2col_streamer_pkg::*;
#(
  parameter int S2P_SIZE = S2P_SIZE_DEF,
  parameter int KSIZE    = 3,
  parameter int IMG_H    = 4,
  parameter int IMG_W    = 4,
  parameter int CH       = 1,
  parameter int NUM_FILT = 1,
  parameter int PAD      = 1,
  parameter int STRIDE   = 1,
  localparam int OH      = (IMG_H + 2 * PAD - KSIZE) / STRIDE + 1,
  localparam int OW      = (IMG_W + 2 * PAD - KSIZE) / STRIDE + 1,
  localparam int T_AW    = clog2_min1(CH * IMG_H * IMG_W),
  localparam int W_AW    = clog2_min1(NUM_FILT * CH * KSIZE * KSIZE)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_go,
  output logic            o_start,
  output logic            o_t_rd_en,
  output logic [T_AW-1:0] o_t_addr,
  output logic            o_w_rd_en,
  output logic [W_AW-1:0] o_w_addr,
  output logic            o_t_padding_zero,
  output logic            o_w_padding_zero,
  output logic            o_busy,
  output logic            o_done
);

  localparam int CW = clog2_min1(S2P_SIZE + 1);
  localparam int IW = T_AW + 2;

  localparam logic [CW-1:0]        K_C   = CW'(KSIZE);
  localparam logic signed [IW-1:0] IMG_HS = IW'(IMG_H);
  localparam logic signed [IW-1:0] IMG_WS = IW'(IMG_W);

  state_e state_q, state_d;
  logic   issue;

  logic [CW-1:0]        cnt_tx, cnt_ty;
  logic signed [IW-1:0] cnt_iy, cnt_ix;
  logic [T_AW-1:0]      cnt_t_addr;
  logic [W_AW-1:0]      cnt_w_addr;
  logic                 cnt_last;

  logic kpad, ipad, t_pad, w_pad;

  logic            start_q, start_d, done_q, done_d, last_q, last_d;
  logic            t_rd_q, t_rd_d, w_rd_q, w_rd_d;
  logic            t_pad_q, t_pad_d, w_pad_q, w_pad_d;
  logic [T_AW-1:0] t_addr_q, t_addr_d;
  logic [W_AW-1:0] w_addr_q, w_addr_d;

  img2col_win_cnt #(
    .S2P_SIZE(S2P_SIZE), .KSIZE(KSIZE), .IMG_H(IMG_H), .IMG_W(IMG_W),
    .CH(CH), .NUM_FILT(NUM_FILT), .PAD(PAD), .STRIDE(STRIDE),
    .OH(OH), .OW(OW), .T_AW(T_AW), .W_AW(W_AW), .IW(IW), .CW(CW)
  ) u_win_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .adv_i    (issue),
    .tx_o     (cnt_tx),
    .ty_o     (cnt_ty),
    .iy_o     (cnt_iy),
    .ix_o     (cnt_ix),
    .t_addr_o (cnt_t_addr),
    .w_addr_o (cnt_w_addr),
    .last_o   (cnt_last)
  );

  // Kernel-pad covers tile positions beyond the kernel; image-pad covers reads outside the map.
  assign kpad  = (cnt_ty >= K_C) | (cnt_tx >= K_C);
  assign ipad  = cnt_iy[IW-1] | cnt_ix[IW-1] | (cnt_iy >= IMG_HS) | (cnt_ix >= IMG_WS);
  assign t_pad = kpad | ipad;
  assign w_pad = kpad;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and beat issue: the first beat issues on the go edge, RUN holds
  // until the registered last beat has been presented, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_go) begin
        state_d = ST_RUN;
        issue   = 1'b1;
      end
      ST_RUN: if (last_q) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        issue = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat payload: padded addresses collapse to 0; idle cycles drive all zeros.
  always_comb begin
    start_d  = issue;
    last_d   = issue & cnt_last;
    t_pad_d  = issue & t_pad;
    w_pad_d  = issue & w_pad;
    t_addr_d = (issue & ~t_pad) ? cnt_t_addr : '0;
    w_addr_d = (issue & ~w_pad) ? cnt_w_addr : '0;
`ifdef IMG2COL_PAD_RDSKIP_EN
    t_rd_d   = issue & ~t_pad;
    w_rd_d   = issue & ~w_pad;
`else
    t_rd_d   = issue;
    w_rd_d   = issue;
`endif
  end

  // Output registers; all beat fields change together on one edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q <= 1'b0; done_q <= 1'b0; last_q <= 1'b0;
      t_rd_q <= 1'b0; w_rd_q <= 1'b0; t_pad_q <= 1'b0; w_pad_q <= 1'b0;
      t_addr_q <= '0; w_addr_q <= '0;
    end else begin
      start_q <= start_d; done_q <= done_d; last_q <= last_d;
      t_rd_q <= t_rd_d; w_rd_q <= w_rd_d; t_pad_q <= t_pad_d; w_pad_q <= w_pad_d;
      t_addr_q <= t_addr_d; w_addr_q <= w_addr_d;
    end
  end

  assign o_start          = start_q;
  assign o_t_rd_en        = t_rd_q;
  assign o_w_rd_en        = w_rd_q;
  assign o_t_addr         = t_addr_q;
  assign o_w_addr         = w_addr_q;
  assign o_t_padding_zero = t_pad_q;
  assign o_w_padding_zero = w_pad_q;
  assign o_busy           = (state_q != ST_IDLE);
  assign o_done           = done_q;

endmodule

// File: tb/tb_img2col_streamer.sv
// Bench for img2col_streamer: three configurations (defaults; KSIZE=2/PAD=0;
// CH=2/NUM_FILT=2) checked beat by beat against an index-decomposition model.
module tb_img2col_streamer;

  localparam int IMG_H = 4, IMG_W = 4, S2P = 3, STRIDE = 1;

  int cfg_k   [3] = '{3, 2, 3};
  int cfg_pad [3] = '{1, 0, 1};
  int cfg_ch  [3] = '{1, 1, 2};
  int cfg_nf  [3] = '{1, 1, 2};

  int vectors = 0;
  int miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rstn, go;
  logic [2:0] st, trd, wrd, tp, wp, by, dn;
  logic [3:0] taddr0, taddr1, waddr0;
  logic [4:0] taddr2;
  logic [1:0] waddr1;
  logic [5:0] waddr2;
  logic [1:0] sel = 2'd0;

  img2col_streamer #(.KSIZE(3), .PAD(1)) u_def (
    .clk(clk), .rstn(rstn[0]), .i_go(go[0]), .o_start(st[0]), .o_t_rd_en(trd[0]),
    .o_t_addr(taddr0), .o_w_rd_en(wrd[0]), .o_w_addr(waddr0),
    .o_t_padding_zero(tp[0]), .o_w_padding_zero(wp[0]), .o_busy(by[0]), .o_done(dn[0]));

  img2col_streamer #(.KSIZE(2), .PAD(0)) u_k2 (
    .clk(clk), .rstn(rstn[1]), .i_go(go[1]), .o_start(st[1]), .o_t_rd_en(trd[1]),
    .o_t_addr(taddr1), .o_w_rd_en(wrd[1]), .o_w_addr(waddr1),
    .o_t_padding_zero(tp[1]), .o_w_padding_zero(wp[1]), .o_busy(by[1]), .o_done(dn[1]));

  img2col_streamer #(.CH(2), .NUM_FILT(2)) u_big (
    .clk(clk), .rstn(rstn[2]), .i_go(go[2]), .o_start(st[2]), .o_t_rd_en(trd[2]),
    .o_t_addr(taddr2), .o_w_rd_en(wrd[2]), .o_w_addr(waddr2),
    .o_t_padding_zero(tp[2]), .o_w_padding_zero(wp[2]), .o_busy(by[2]), .o_done(dn[2]));

  int o_st, o_trd, o_wrd, o_tp, o_wp, o_by, o_dn, o_ta, o_wa;

  // Route the selected instance to the observation variables.
  always_comb begin
    o_st = int'(st[sel]); o_trd = int'(trd[sel]); o_wrd = int'(wrd[sel]);
    o_tp = int'(tp[sel]); o_wp = int'(wp[sel]); o_by = int'(by[sel]); o_dn = int'(dn[sel]);
    o_ta = 0; o_wa = 0;
    case (sel)
      2'd0: begin o_ta = int'(taddr0); o_wa = int'(waddr0); end
      2'd1: begin o_ta = int'(taddr1); o_wa = int'(waddr1); end
      default: begin o_ta = int'(taddr2); o_wa = int'(waddr2); end
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_st, input int e_tp, input int e_wp,
                         input int e_ta, input int e_wa, input int e_by, input int e_dn);
    int e_trd, e_wrd;
`ifdef IMG2COL_PAD_RDSKIP_EN
    e_trd = e_st & ~e_tp & 1;
    e_wrd = e_st & ~e_wp & 1;
`else
    e_trd = e_st;
    e_wrd = e_st;
`endif
    chk({tag, ".start"}, o_st, e_st);
    chk({tag, ".t_pad"}, o_tp, e_tp);
    chk({tag, ".w_pad"}, o_wp, e_wp);
    chk({tag, ".t_addr"}, o_ta, e_ta);
    chk({tag, ".w_addr"}, o_wa, e_wa);
    chk({tag, ".t_rd_en"}, o_trd, e_trd);
    chk({tag, ".w_rd_en"}, o_wrd, e_wrd);
    chk({tag, ".busy"}, o_by, e_by);
    chk({tag, ".done"}, o_dn, e_dn);
  endtask

  function automatic int n_oh(input int s);
    return (IMG_H + 2 * cfg_pad[s] - cfg_k[s]) / STRIDE + 1;
  endfunction

  function automatic int n_ow(input int s);
    return (IMG_W + 2 * cfg_pad[s] - cfg_k[s]) / STRIDE + 1;
  endfunction

  function automatic int n_beats(input int s);
    return cfg_nf[s] * n_oh(s) * n_ow(s) * cfg_ch[s] * S2P * S2P;
  endfunction

  // Reference: decompose the beat index into loop coordinates and apply the conv rules.
  task automatic model(input int s, input int n, output int tpad, output int wpad,
                       output int ta, output int wa);
    int tx, ty, c, ox, oy, f, iy, ix, k, q;
    k  = cfg_k[s];
    tx = n % S2P;             q = n / S2P;
    ty = q % S2P;             q = q / S2P;
    c  = q % cfg_ch[s];       q = q / cfg_ch[s];
    ox = q % n_ow(s);         q = q / n_ow(s);
    oy = q % n_oh(s);         f = q / n_oh(s);
    iy = oy * STRIDE + ty - cfg_pad[s];
    ix = ox * STRIDE + tx - cfg_pad[s];
    wpad = (ty >= k || tx >= k) ? 1 : 0;
    tpad = (wpad == 1 || iy < 0 || iy >= IMG_H || ix < 0 || ix >= IMG_W) ? 1 : 0;
    ta = tpad ? 0 : c * IMG_H * IMG_W + iy * IMG_W + ix;
    wa = wpad ? 0 : f * cfg_ch[s] * k * k + c * k * k + ty * k + tx;
  endtask

  // One job on instance s; optional stray go in RUN / DONE, optional reset abort at a beat.
  task automatic run_job(input int s, input int go_again_at, input bit go_in_done,
                         input int abort_at);
    int total, tpad, wpad, ta, wa;
    total = n_beats(s);
    sel = 2'(s);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    go[s] = 1'b1;
    @(negedge clk);
    go[s] = 1'b0;
    for (int n = 0; n < total; n++) begin
      model(s, n, tpad, wpad, ta, wa);
      chk_all($sformatf("cfg%0d.beat%0d", s, n), 1, tpad, wpad, ta, wa, 1, 0);
      if (n == abort_at) begin
        rstn[s] = 1'b0;
        #1;
        chk_all($sformatf("cfg%0d.abort%0d", s, n), 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn[s] = 1'b1;
        @(negedge clk);
        chk_all($sformatf("cfg%0d.post_abort", s), 0, 0, 0, 0, 0, 0, 0);
        $display("job cfg%0d aborted at beat %0d", s, n);
        return;
      end
      if (n == go_again_at) go[s] = 1'b1;
      @(negedge clk);
      go[s] = 1'b0;
    end
    chk_all($sformatf("cfg%0d.done", s), 0, 0, 0, 0, 0, 1, 1);
    if (go_in_done) go[s] = 1'b1;
    @(negedge clk);
    go[s] = 1'b0;
    chk_all($sformatf("cfg%0d.idle", s), 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all($sformatf("cfg%0d.idle2", s), 0, 0, 0, 0, 0, 0, 0);
    $display("job cfg%0d: %0d beats, stray go at %0d, go in done %0d", s, total,
             go_again_at, go_in_done);
  endtask

  initial begin
    rstn = 3'b000;
    go   = 3'b000;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk_all($sformatf("cfg%0d.reset", s), 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rstn = 3'b111;
    @(negedge clk);

    run_job(0, -1, 1'b0, -1);
    run_job(0, 50, 1'b1, -1);
    run_job(0, int'($urandom_range(0, 143)), 1'b1, -1);
    run_job(0, -1, 1'b0, 70);
    run_job(0, -1, 1'b0, -1);
    run_job(0, -1, 1'b0, int'($urandom_range(0, 143)));
    run_job(0, int'($urandom_range(0, 143)), 1'b0, -1);
    run_job(1, -1, 1'b0, -1);
    run_job(1, int'($urandom_range(0, 80)), 1'b1, -1);
    run_job(2, int'($urandom_range(0, 575)), 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
